// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's control inputs and PC/status outputs.
// The master side (top level, decoder, bench) drives controls; the slave side is the sequencer.
interface fetch_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          start;
  logic          stall;
  logic          halt;
  logic          branch_taken;
  logic          branch_abs;
  logic [D-1:0]  branch_target;
  logic [D-1:0]  pc;
  logic          fetch_valid;
  logic          done;
  logic [CW-1:0] instr_count;

  modport master (
    output start, stall, halt, branch_taken, branch_abs, branch_target,
    input  pc, fetch_valid, done, instr_count
  );

  modport slave (
    input  start, stall, halt, branch_taken, branch_abs, branch_target,
    output pc, fetch_valid, done, instr_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a combinational instruction ROM.
// States: IDLE | waiting for start, pc parked at 0
//         RUN  | fetching, pc advances / branches / stalls each edge
//         DONE | halt retired; pc and instr_count held for readout
module fetch_sequencer #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.slave  fetch_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [D-1:0]  pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;
  logic [D-1:0]  branch_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating retire count; a D-bit add gives modular relative branches for free.
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  assign branch_pc = fetch_if.branch_abs ? fetch_if.branch_target
                                         : pc_q + fetch_if.branch_target;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        pc_d = '0;
        if (fetch_if.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (fetch_if.stall) begin
          pc_d  = pc_q;
          cnt_d = cnt_q;
        end else if (fetch_if.halt) begin
          state_d = ST_DONE;
          cnt_d   = cnt_inc;
        end else if (fetch_if.branch_taken) begin
          pc_d  = branch_pc;
          cnt_d = cnt_inc;
        end else begin
          pc_d  = pc_q + D'(1);
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        if (fetch_if.start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        cnt_d   = '0;
      end
    endcase
  end

  assign fetch_if.pc          = pc_q;
  assign fetch_if.fetch_valid = (state_q == ST_RUN);
  assign fetch_if.done        = (state_q == ST_DONE);
  assign fetch_if.instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: stimulus pushes expected post-edge state into a
// queue, a negedge monitor pops and compares. A CW=4 copy shares stimulus for saturation.
module tb_fetch_sequencer;

  localparam int D = 12;
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

  logic clk;
  logic reset;

  fetch_sequencer_if #(.D(D), .CW(16)) m_if ();
  fetch_sequencer_if #(.D(D), .CW(4))  s_if ();

  fetch_sequencer #(.D(D), .CW(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .fetch_if (m_if)
  );

  fetch_sequencer #(.D(D), .CW(4)) dut_sat (
    .clk      (clk),
    .reset    (reset),
    .fetch_if (s_if)
  );

  assign s_if.start         = m_if.start;
  assign s_if.stall         = m_if.stall;
  assign s_if.halt          = m_if.halt;
  assign s_if.branch_taken  = m_if.branch_taken;
  assign s_if.branch_abs    = m_if.branch_abs;
  assign s_if.branch_target = m_if.branch_target;

  typedef struct {
    logic [1:0]  st;
    logic [11:0] pc;
    logic [15:0] cnt;
    logic [3:0]  scnt;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int passed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("fetch_valid", 32'(m_if.fetch_valid), 32'(e.st == S_RUN));
      chk("done",        32'(m_if.done),        32'(e.st == S_DONE));
      chk("pc",          32'(m_if.pc),          32'(e.pc));
      chk("instr_count", 32'(m_if.instr_count), 32'(e.cnt));
      chk("sat_count",   32'(s_if.instr_count), 32'(e.scnt));
    end else if (m_if.fetch_valid === 1'b1 || m_if.done === 1'b1) begin
      total++;
      $display("FAIL unexpected_output: fetch_valid=%0b done=%0b with no expectation queued",
               m_if.fetch_valid, m_if.done);
    end
  end

  // Drive inputs, take one edge, queue the state expected after that edge.
  task automatic step(input logic st, input logic sl, input logic hl, input logic bt,
                      input logic ba, input logic [11:0] tg,
                      input logic [1:0] es, input logic [11:0] epc, input logic [15:0] ec);
    exp_t e;
    m_if.start         = st;
    m_if.stall         = sl;
    m_if.halt          = hl;
    m_if.branch_taken  = bt;
    m_if.branch_abs    = ba;
    m_if.branch_target = tg;
    @(posedge clk);
    e.st   = es;
    e.pc   = epc;
    e.cnt  = ec;
    e.scnt = (ec > 16'd15) ? 4'd15 : ec[3:0];
    q.push_back(e);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    step(0,0,0,0,0,12'h000, S_IDLE, 12'h000, 0);
    reset = 1'b0;
    step(0,0,0,0,0,12'h000, S_IDLE, 12'h000, 0);

    // Sequential run, halt at pc=5
    step(1,0,0,0,0,12'h000, S_RUN, 12'h000, 0);
    for (int i = 1; i <= 5; i++) step(0,0,0,0,0,12'h000, S_RUN, 12'(i), 16'(i));
    step(0,0,1,0,0,12'h000, S_DONE, 12'h005, 6);
    step(0,0,0,0,0,12'h000, S_DONE, 12'h005, 6);

    // Restart, absolute branch at pc=3, start ignored in RUN
    step(1,0,0,0,0,12'h000, S_RUN, 12'h000, 0);
    for (int i = 1; i <= 3; i++) step(0,0,0,0,0,12'h000, S_RUN, 12'(i), 16'(i));
    step(0,0,0,1,1,12'h100, S_RUN, 12'h100, 4);
    step(0,0,0,0,0,12'h000, S_RUN, 12'h101, 5);
    step(1,0,0,0,0,12'h000, S_RUN, 12'h102, 6);

    // Relative branches, modular wrap, sequential wrap, self-loop
    step(0,0,0,1,1,12'h010, S_RUN, 12'h010, 7);
    step(0,0,0,1,0,12'hFFC, S_RUN, 12'h00C, 8);
    step(0,0,0,1,1,12'hFFE, S_RUN, 12'hFFE, 9);
    step(0,0,0,1,0,12'h005, S_RUN, 12'h003, 10);
    step(0,0,0,1,1,12'hFFF, S_RUN, 12'hFFF, 11);
    step(0,0,0,0,0,12'h000, S_RUN, 12'h000, 12);
    step(0,0,0,1,0,12'h000, S_RUN, 12'h000, 13);

    // Stall beats halt and branch; then halt beats branch
    step(0,0,0,1,1,12'h007, S_RUN, 12'h007, 14);
    for (int i = 0; i < 3; i++) step(0,1,1,1,1,12'h055, S_RUN, 12'h007, 14);
    step(0,0,1,1,1,12'h055, S_DONE, 12'h007, 15);
    step(0,0,0,1,1,12'h055, S_DONE, 12'h007, 15);

    // Restart from DONE, reset mid-run discards the pending branch
    step(1,0,0,0,0,12'h000, S_RUN, 12'h000, 0);
    step(0,0,0,1,1,12'h020, S_RUN, 12'h020, 1);
    reset = 1'b1;
    step(0,0,0,1,1,12'h050, S_IDLE, 12'h000, 0);
    reset = 1'b0;
    step(0,0,1,1,1,12'h050, S_IDLE, 12'h000, 0);

    // Saturation on the CW=4 instance over 20 sequential instructions
    step(1,0,0,0,0,12'h000, S_RUN, 12'h000, 0);
    for (int i = 1; i <= 20; i++) step(0,0,0,0,0,12'h000, S_RUN, 12'(i), 16'(i));
    step(0,0,1,0,0,12'h000, S_DONE, 12'd20, 21);

    // Reset outranks start
    reset = 1'b1;
    step(1,0,0,0,0,12'h000, S_IDLE, 12'h000, 0);
    reset = 1'b0;
    step(0,0,0,0,0,12'h000, S_IDLE, 12'h000, 0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
